// File: rtl/quadrilatero_pkg.sv
// +----------------------------------------------------------------------------+
// | quadrilatero_pkg                                                           |
// | Shared types and constants for the systolic-array sequencer.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package quadrilatero_pkg;

    localparam int SA_MESH_WIDTH = 4;
    localparam int SA_ID_WIDTH   = 4;
    localparam int SA_FLOW_BEATS = SA_MESH_WIDTH - 1;
    localparam int SA_TILE_W     = $clog2(SA_MESH_WIDTH + 1);

    typedef struct packed {
        logic [SA_TILE_W-1:0] m;
        logic [SA_TILE_W-1:0] k;
        logic [SA_TILE_W-1:0] n;
    } sa_tile_cfg_t;

    typedef struct packed {
        logic       acc_clear;
        logic [1:0] dtype;
    } sa_ctrl_t;

    typedef enum logic [1:0] {
        FEED  = 2'd0,
        FLOW  = 2'd1,
        DRAIN = 2'd2
    } sa_stage_e;

    // Out-of-range tile dimensions (0 or larger than the mesh) mean "full mesh".
    function automatic logic [SA_TILE_W-1:0] sa_clamp_dim(input logic [SA_TILE_W-1:0] v);
        if (v == '0 || int'(v) > SA_MESH_WIDTH) begin
            return SA_TILE_W'(SA_MESH_WIDTH);
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/quadrilatero_sa_stage_slot.sv
// +----------------------------------------------------------------------------+
// | quadrilatero_sa_stage_slot                                                 |
// | One pipeline stage slot: active flag, beat counter and payload register.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module quadrilatero_sa_stage_slot import quadrilatero_pkg::*; #(
    parameter sa_stage_e STAGE      = FEED,
    parameter int        MESH_WIDTH = SA_MESH_WIDTH,
    parameter int        PAYLOAD_W  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_i,
    input  logic [PAYLOAD_W-1:0]          payload_i,
    input  logic                          advance_i,
    output logic                          active_o,
    output logic [$clog2(MESH_WIDTH)-1:0] cnt_o,
    output logic [PAYLOAD_W-1:0]          payload_o,
    output logic                          last_o
);

    localparam int            CW       = $clog2(MESH_WIDTH);
    localparam int            BEATS    = (STAGE == FLOW) ? MESH_WIDTH - 1 : MESH_WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    logic                 active_q, active_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    assign last_o = active_q & (cnt_q == LAST_CNT);

    // A load overrides the release of the previous occupant in the same cycle.
    always_comb begin
        active_d  = active_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        if (load_i) begin
            active_d  = 1'b1;
            cnt_d     = '0;
            payload_d = payload_i;
        end else if (advance_i && active_q) begin
            if (last_o) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            payload_q <= '0;
        end else begin
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
        end
    end

    assign active_o  = active_q;
    assign cnt_o     = cnt_q;
    assign payload_o = payload_q;

endmodule

`default_nettype wire

// File: rtl/quadrilatero_sa_sequencer.sv
// +----------------------------------------------------------------------------+
// | quadrilatero_sa_sequencer                                                  |
// | FEED/FLOW/DRAIN sequencer for the systolic mesh with partial tiles,        |
// | write backpressure and zero-bubble issue.                                  |
// | Option macro: QUADRILATERO_SA_PARTIAL_TILE_EN (partial tile support).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module quadrilatero_sa_sequencer import quadrilatero_pkg::*; #(
    parameter int MESH_WIDTH = SA_MESH_WIDTH,
    parameter int N_REGS     = 8,
    parameter int ID_WIDTH   = SA_ID_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    output logic                          ready_o,
    input  logic [$clog2(N_REGS)-1:0]     data_reg_i,
    input  logic [$clog2(N_REGS)-1:0]     weight_reg_i,
    input  logic [$clog2(N_REGS)-1:0]     acc_reg_i,
    input  logic [ID_WIDTH-1:0]           id_i,
    input  sa_tile_cfg_t                  tile_i,
    input  sa_ctrl_t                      sa_ctrl_i,
    output logic [$clog2(N_REGS)-1:0]     data_raddr_o,
    output logic [$clog2(N_REGS)-1:0]     weight_raddr_o,
    output logic [$clog2(N_REGS)-1:0]     acc_raddr_o,
    output logic [$clog2(MESH_WIDTH)-1:0] rd_rowaddr_o,
    input  logic                          data_rvalid_i,
    input  logic                          weight_rvalid_i,
    input  logic                          acc_rvalid_i,
    output logic                          data_rready_o,
    output logic                          weight_rready_o,
    output logic                          acc_rready_o,
    output logic                          rd_last_o,
    output logic [MESH_WIDTH-1:0]         data_lane_en_o,
    output logic [MESH_WIDTH-1:0]         weight_lane_en_o,
    output logic [MESH_WIDTH-1:0]         acc_lane_en_o,
    output sa_ctrl_t                      sa_ctrl_o,
    output logic                          pump_o,
    output logic [$clog2(N_REGS)-1:0]     res_waddr_o,
    output logic [$clog2(MESH_WIDTH)-1:0] res_wrowaddr_o,
    output logic                          res_we_o,
    output logic                          res_wlast_o,
    input  logic                          res_wready_i,
    output logic [MESH_WIDTH-1:0]         res_wmask_o,
    output logic [ID_WIDTH-1:0]           sa_input_id_o,
    output logic [ID_WIDTH-1:0]           sa_output_id_o,
    output logic                          finished_o,
    output logic [ID_WIDTH-1:0]           finished_id_o,
    input  logic                          finished_ack_i
);

    localparam int RW = $clog2(N_REGS);
    localparam int CW = $clog2(MESH_WIDTH);

    typedef struct packed {
        logic [RW-1:0]       dreg;
        logic [RW-1:0]       wreg;
        logic [RW-1:0]       areg;
        logic [ID_WIDTH-1:0] id;
        sa_tile_cfg_t        tile;
        sa_ctrl_t            ctrl;
    } slot_payload_t;

    localparam int PW = $bits(slot_payload_t);

    function automatic logic row_lt(input logic [CW-1:0] r, input logic [SA_TILE_W-1:0] lim);
        return int'(r) < int'(lim);
    endfunction

    slot_payload_t       issue_pl, feed_pl, flow_pl, drain_pl;
    logic                feed_active, flow_active, drain_active;
    logic                feed_last, flow_last, drain_last;
    logic [CW-1:0]       feed_cnt, flow_cnt, drain_cnt;
    logic                beat, issue;
    logic                need_d, need_w, need_wr;
    logic                feed_ok, drain_ok, fin_block;
    logic                finished_q, finished_d;
    logic [ID_WIDTH-1:0] finished_id_q, finished_id_d;

    always_comb begin
        issue_pl      = '0;
        issue_pl.dreg = data_reg_i;
        issue_pl.wreg = weight_reg_i;
        issue_pl.areg = acc_reg_i;
        issue_pl.id   = id_i;
        issue_pl.ctrl = sa_ctrl_i;
`ifdef QUADRILATERO_SA_PARTIAL_TILE_EN
        issue_pl.tile.m = sa_clamp_dim(tile_i.m);
        issue_pl.tile.k = sa_clamp_dim(tile_i.k);
        issue_pl.tile.n = sa_clamp_dim(tile_i.n);
`else
        issue_pl.tile.m = SA_TILE_W'(MESH_WIDTH);
        issue_pl.tile.k = SA_TILE_W'(MESH_WIDTH);
        issue_pl.tile.n = SA_TILE_W'(MESH_WIDTH);
`endif
    end

`ifndef QUADRILATERO_SA_PARTIAL_TILE_EN
    logic unused_tile;
    assign unused_tile = ^tile_i;
`endif

    quadrilatero_sa_stage_slot #(.STAGE(FEED), .MESH_WIDTH(MESH_WIDTH), .PAYLOAD_W(PW)) u_feed (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (issue),
        .payload_i (issue_pl),
        .advance_i (beat),
        .active_o  (feed_active),
        .cnt_o     (feed_cnt),
        .payload_o (feed_pl),
        .last_o    (feed_last)
    );

    quadrilatero_sa_stage_slot #(.STAGE(FLOW), .MESH_WIDTH(MESH_WIDTH), .PAYLOAD_W(PW)) u_flow (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (feed_last & beat),
        .payload_i (feed_pl),
        .advance_i (beat),
        .active_o  (flow_active),
        .cnt_o     (flow_cnt),
        .payload_o (flow_pl),
        .last_o    (flow_last)
    );

    quadrilatero_sa_stage_slot #(.STAGE(DRAIN), .MESH_WIDTH(MESH_WIDTH), .PAYLOAD_W(PW)) u_drain (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (flow_last & beat),
        .payload_i (flow_pl),
        .advance_i (beat),
        .active_o  (drain_active),
        .cnt_o     (drain_cnt),
        .payload_o (drain_pl),
        .last_o    (drain_last)
    );

    // A single global beat: any unmet condition freezes all three slots together.
    always_comb begin
        need_d    = feed_active & row_lt(feed_cnt, feed_pl.tile.m);
        need_w    = feed_active & row_lt(feed_cnt, feed_pl.tile.k);
        need_wr   = drain_active & row_lt(drain_cnt, drain_pl.tile.m);
        feed_ok   = (~need_d | data_rvalid_i) & (~need_w | weight_rvalid_i) & (~need_d | acc_rvalid_i);
        drain_ok  = ~need_wr | res_wready_i;
        fin_block = drain_last & finished_q & ~finished_ack_i;
        beat      = (feed_active | flow_active | drain_active) & feed_ok & drain_ok & ~fin_block;
    end

    assign ready_o = ~feed_active | (feed_last & beat);
    assign issue   = start_i & ready_o;

    always_comb begin
        data_lane_en_o   = '0;
        weight_lane_en_o = '0;
        acc_lane_en_o    = '0;
        res_wmask_o      = '0;
        for (int j = 0; j < MESH_WIDTH; j++) begin
            data_lane_en_o[j]   = need_d & (j < int'(feed_pl.tile.k));
            weight_lane_en_o[j] = need_w & (j < int'(feed_pl.tile.n));
            acc_lane_en_o[j]    = need_d & (j < int'(feed_pl.tile.n));
            res_wmask_o[j]      = drain_active & (j < int'(drain_pl.tile.n));
        end
    end

    // A new completion takes priority over the acknowledge of the old one.
    always_comb begin
        finished_d    = finished_q;
        finished_id_d = finished_id_q;
        if (drain_last && beat) begin
            finished_d    = 1'b1;
            finished_id_d = drain_pl.id;
        end else if (finished_ack_i) begin
            finished_d    = 1'b0;
            finished_id_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            finished_q    <= 1'b0;
            finished_id_q <= '0;
        end else begin
            finished_q    <= finished_d;
            finished_id_q <= finished_id_d;
        end
    end

    assign data_raddr_o    = feed_pl.dreg;
    assign weight_raddr_o  = feed_pl.wreg;
    assign acc_raddr_o     = feed_pl.areg;
    assign rd_rowaddr_o    = feed_cnt;
    assign data_rready_o   = need_d & beat;
    assign weight_rready_o = need_w & beat;
    assign acc_rready_o    = need_d & beat;
    assign rd_last_o       = feed_last;
    assign sa_ctrl_o       = feed_pl.ctrl;
    assign pump_o          = beat;
    assign res_waddr_o     = drain_pl.areg;
    assign res_wrowaddr_o  = drain_cnt;
    assign res_we_o        = need_wr & beat;
    assign res_wlast_o     = drain_last;
    assign sa_input_id_o   = feed_pl.id;
    assign sa_output_id_o  = drain_pl.id;
    assign finished_o      = finished_q;
    assign finished_id_o   = finished_id_q;

    logic unused_slot_bits;
    assign unused_slot_bits = ^{drain_pl.dreg, drain_pl.wreg, drain_pl.tile.k, drain_pl.ctrl, flow_cnt};

endmodule

`default_nettype wire

// File: tb/tb_quadrilatero_sa_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_quadrilatero_sa_sequencer                                               |
// | Self-checking bench: per-instruction beat-count model vs. the sequencer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_quadrilatero_sa_sequencer;
    import quadrilatero_pkg::*;

    localparam int MW  = 4;
    localparam int NR  = 8;
    localparam int IDW = SA_ID_WIDTH;
    localparam int RW  = $clog2(NR);
    localparam int CWD = $clog2(MW);
    localparam int CTW = $bits(sa_ctrl_t);

    logic clk;
    logic rst_i, start_i, ready_o;
    logic [RW-1:0] data_reg_i, weight_reg_i, acc_reg_i;
    logic [IDW-1:0] id_i;
    sa_tile_cfg_t tile_i;
    sa_ctrl_t sa_ctrl_i, sa_ctrl_o;
    logic [RW-1:0] data_raddr_o, weight_raddr_o, acc_raddr_o, res_waddr_o;
    logic [CWD-1:0] rd_rowaddr_o, res_wrowaddr_o;
    logic data_rvalid_i, weight_rvalid_i, acc_rvalid_i;
    logic data_rready_o, weight_rready_o, acc_rready_o, rd_last_o;
    logic [MW-1:0] data_lane_en_o, weight_lane_en_o, acc_lane_en_o, res_wmask_o;
    logic pump_o, res_we_o, res_wlast_o, res_wready_i;
    logic [IDW-1:0] sa_input_id_o, sa_output_id_o, finished_id_o;
    logic finished_o, finished_ack_i;

    quadrilatero_sa_sequencer #(.MESH_WIDTH(MW), .N_REGS(NR), .ID_WIDTH(IDW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o),
        .data_reg_i(data_reg_i), .weight_reg_i(weight_reg_i), .acc_reg_i(acc_reg_i),
        .id_i(id_i), .tile_i(tile_i), .sa_ctrl_i(sa_ctrl_i),
        .data_raddr_o(data_raddr_o), .weight_raddr_o(weight_raddr_o), .acc_raddr_o(acc_raddr_o),
        .rd_rowaddr_o(rd_rowaddr_o),
        .data_rvalid_i(data_rvalid_i), .weight_rvalid_i(weight_rvalid_i), .acc_rvalid_i(acc_rvalid_i),
        .data_rready_o(data_rready_o), .weight_rready_o(weight_rready_o), .acc_rready_o(acc_rready_o),
        .rd_last_o(rd_last_o),
        .data_lane_en_o(data_lane_en_o), .weight_lane_en_o(weight_lane_en_o), .acc_lane_en_o(acc_lane_en_o),
        .sa_ctrl_o(sa_ctrl_o), .pump_o(pump_o),
        .res_waddr_o(res_waddr_o), .res_wrowaddr_o(res_wrowaddr_o), .res_we_o(res_we_o),
        .res_wlast_o(res_wlast_o), .res_wready_i(res_wready_i), .res_wmask_o(res_wmask_o),
        .sa_input_id_o(sa_input_id_o), .sa_output_id_o(sa_output_id_o),
        .finished_o(finished_o), .finished_id_o(finished_id_o), .finished_ack_i(finished_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each in-flight instruction is tracked by the number of beats since issue:
    // [0,MW) feeding, [MW,2MW-1) flowing, [2MW-1,3MW-1) draining.
    typedef struct {
        int id; int dreg; int wreg; int areg; int m; int k; int n; int ctrl; int b;
    } ins_t;

    ins_t q[$];
    ins_t e_feed, e_drain;
    int   fin_v, fin_id;
    int   n_tests, n_fail;
    int   e_fi, e_di, e_drow;
    bit   e_pump, e_ready, e_issue, e_drr, e_wrr, e_arr, e_we, e_rdlast, e_wlast, last_issue;
    logic [MW-1:0] e_dl, e_wl, e_al, e_wm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int v);
`ifdef QUADRILATERO_SA_PARTIAL_TILE_EN
        return (v == 0 || v > MW) ? MW : v;
`else
        v = MW;
        return v;
`endif
    endfunction

    task automatic drive(input bit st, input int id, input int m, input int k, input int n,
                         input bit dv, input bit wv, input bit av, input bit wr, input bit ack);
        start_i         = st;
        id_i            = IDW'(id);
        tile_i.m        = SA_TILE_W'(m);
        tile_i.k        = SA_TILE_W'(k);
        tile_i.n        = SA_TILE_W'(n);
        data_reg_i      = RW'($urandom_range(0, NR - 1));
        weight_reg_i    = RW'($urandom_range(0, NR - 1));
        acc_reg_i       = RW'($urandom_range(0, NR - 1));
        sa_ctrl_i       = sa_ctrl_t'(CTW'($urandom));
        data_rvalid_i   = dv;
        weight_rvalid_i = wv;
        acc_rvalid_i    = av;
        res_wready_i    = wr;
        finished_ack_i  = ack;
    endtask

    task automatic model_eval();
        int fr, dr;
        bit nd, nw, nr, f_ok, d_ok, lastd;
        e_fi = -1; e_di = -1; e_drow = 0;
        foreach (q[i]) begin
            if (q[i].b < MW) e_fi = i;
            if (q[i].b >= 2 * MW - 1) e_di = i;
        end
        e_dl = '0; e_wl = '0; e_al = '0; e_wm = '0;
        nd = 0; nw = 0; nr = 0; lastd = 0; f_ok = 1; d_ok = 1;
        if (e_fi >= 0) begin
            e_feed = q[e_fi];
            fr = e_feed.b;
            nd = fr < e_feed.m;
            nw = fr < e_feed.k;
            f_ok = (!nd || data_rvalid_i) && (!nw || weight_rvalid_i) && (!nd || acc_rvalid_i);
            for (int j = 0; j < MW; j++) begin
                e_dl[j] = nd && (j < e_feed.k);
                e_wl[j] = nw && (j < e_feed.n);
                e_al[j] = nd && (j < e_feed.n);
            end
        end
        if (e_di >= 0) begin
            e_drain = q[e_di];
            dr = e_drain.b - (2 * MW - 1);
            e_drow = dr;
            nr = dr < e_drain.m;
            d_ok = !nr || res_wready_i;
            lastd = (dr == MW - 1);
            for (int j = 0; j < MW; j++) e_wm[j] = (j < e_drain.n);
        end
        e_pump   = (q.size() > 0) && f_ok && d_ok && !(lastd && fin_v != 0 && !finished_ack_i);
        e_ready  = (e_fi < 0) || (e_feed.b == MW - 1 && e_pump);
        e_issue  = start_i && e_ready;
        e_drr    = nd && e_pump;
        e_wrr    = nw && e_pump;
        e_arr    = nd && e_pump;
        e_we     = nr && e_pump;
        e_rdlast = (e_fi >= 0) && (e_feed.b == MW - 1);
        e_wlast  = lastd;
    endtask

    task automatic model_commit();
        ins_t n;
        bit   done;
        int   did;
        done = 0; did = 0;
        last_issue = e_issue;
        if (e_pump) begin
            foreach (q[i]) q[i].b++;
            if (q.size() > 0 && q[0].b == 3 * MW - 1) begin
                did = q[0].id;
                void'(q.pop_front());
                done = 1;
            end
        end
        if (done) begin
            fin_v = 1; fin_id = did;
        end else if (finished_ack_i) begin
            fin_v = 0; fin_id = 0;
        end
        if (e_issue) begin
            n.id = int'(id_i); n.dreg = int'(data_reg_i); n.wreg = int'(weight_reg_i);
            n.areg = int'(acc_reg_i); n.ctrl = int'(sa_ctrl_i);
            n.m = eff(int'(tile_i.m)); n.k = eff(int'(tile_i.k)); n.n = eff(int'(tile_i.n));
            n.b = 0;
            q.push_back(n);
        end
    endtask

    task automatic compare_all();
        chk("pump", 32'(pump_o), 32'(e_pump));
        chk("ready", 32'(ready_o), 32'(e_ready));
        chk("data_rready", 32'(data_rready_o), 32'(e_drr));
        chk("weight_rready", 32'(weight_rready_o), 32'(e_wrr));
        chk("acc_rready", 32'(acc_rready_o), 32'(e_arr));
        chk("data_lane", 32'(data_lane_en_o), 32'(e_dl));
        chk("weight_lane", 32'(weight_lane_en_o), 32'(e_wl));
        chk("acc_lane", 32'(acc_lane_en_o), 32'(e_al));
        chk("res_we", 32'(res_we_o), 32'(e_we));
        chk("res_wmask", 32'(res_wmask_o), 32'(e_wm));
        chk("res_wlast", 32'(res_wlast_o), 32'(e_wlast));
        chk("rd_last", 32'(rd_last_o), 32'(e_rdlast));
        chk("finished", 32'(finished_o), 32'(fin_v));
        chk("finished_id", 32'(finished_id_o), 32'(fin_id));
        if (e_fi >= 0) begin
            chk("rd_row", 32'(rd_rowaddr_o), 32'(e_feed.b));
            chk("data_raddr", 32'(data_raddr_o), 32'(e_feed.dreg));
            chk("weight_raddr", 32'(weight_raddr_o), 32'(e_feed.wreg));
            chk("acc_raddr", 32'(acc_raddr_o), 32'(e_feed.areg));
            chk("input_id", 32'(sa_input_id_o), 32'(e_feed.id));
            chk("sa_ctrl", 32'(sa_ctrl_o), 32'(e_feed.ctrl));
        end
        if (e_di >= 0) begin
            chk("res_waddr", 32'(res_waddr_o), 32'(e_drain.areg));
            chk("res_wrow", 32'(res_wrowaddr_o), 32'(e_drow));
            chk("output_id", 32'(sa_output_id_o), 32'(e_drain.id));
        end
    endtask

    task automatic step();
        model_eval();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_pump"}, 32'(pump_o), 32'd0);
        chk({tag, "_finished"}, 32'(finished_o), 32'd0);
        chk({tag, "_finished_id"}, 32'(finished_id_o), 32'd0);
        chk({tag, "_rready"}, 32'({data_rready_o, weight_rready_o, acc_rready_o, rd_last_o}), 32'd0);
        chk({tag, "_lanes"}, 32'({data_lane_en_o, weight_lane_en_o, acc_lane_en_o, res_wmask_o}), 32'd0);
        chk({tag, "_we"}, 32'({res_we_o, res_wlast_o}), 32'd0);
        chk({tag, "_addrs"}, 32'({data_raddr_o, weight_raddr_o, acc_raddr_o, res_waddr_o}), 32'd0);
        chk({tag, "_rows"}, 32'({rd_rowaddr_o, res_wrowaddr_o}), 32'd0);
        chk({tag, "_ids"}, 32'({sa_input_id_o, sa_output_id_o}), 32'd0);
        chk({tag, "_ctrl"}, 32'(sa_ctrl_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t;
        n_tests = 0; n_fail = 0; fin_v = 0; fin_id = 0; last_issue = 0;

        // Reset state
        rst_i = 1'b1;
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_i = 1'b0;

        // Full tile, single issue, latency to finished_o
        drive(1, 5, 4, 4, 4, 1, 1, 1, 1, 0);
        step();
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 0);
        lat = 1;
        while (finished_o !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(3 * MW));
        chk("latency_id", 32'(finished_id_o), 32'd5);
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 1);
        step();

        // Back-to-back issue, ack held high
        drive(1, 1, 4, 4, 4, 1, 1, 1, 1, 1);
        step();
        t = 0;
        last_issue = 0;
        while (!last_issue && t < 10) begin
            drive(1, 2, 4, 4, 4, 1, 1, 1, 1, 1);
            step();
            t++;
        end
        chk("b2b_accept_cycle", 32'(t), 32'(MW));
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 1);
        repeat (16) step();

        // Partial tile m=2 k=3 n=1
        drive(1, 7, 2, 3, 1, 1, 1, 1, 1, 1);
        step();
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 1);
        repeat (14) step();

        // Write backpressure during DRAIN
        drive(1, 9, 4, 4, 4, 1, 1, 1, 1, 1);
        step();
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 1);
        repeat (8) step();
        drive(0, 0, 4, 4, 4, 1, 1, 1, 0, 1);
        repeat (3) step();
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 1);
        repeat (8) step();

        // Unacked completion blocks the next last DRAIN beat
        drive(1, 3, 4, 4, 4, 1, 1, 1, 1, 0);
        step();
        for (int c = 0; c < 30; c++) begin
            drive(c < 6, 4, 4, 4, 4, 1, 1, 1, 1, 0);
            step();
        end
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 1);
        repeat (4) step();

        // Randomized traffic
        for (int c = 0; c < 700; c++) begin
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step();
        end
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 1);
        repeat (20) step();

        // Reset while an instruction is in FLOW
        drive(1, 6, 4, 4, 4, 1, 1, 1, 1, 0);
        step();
        drive(0, 0, 4, 4, 4, 1, 1, 1, 1, 0);
        repeat (5) step();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        fin_v = 0; fin_id = 0;
        check_reset("reset_flow");
        rst_i = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
